// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter load/count controller: FSM states, result
// codes and the width of the per-request cycle counter.
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_COUNT = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      STAT_OK       = 2'd0,
      STAT_TIMEOUT  = 2'd1,
      STAT_MISMATCH = 2'd2
   } status_t;

   localparam int          CYCLES_W   = 16;
   localparam logic [15:0] CYCLES_MAX = 16'hFFFF;

   // Cycle counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] val);
      return (val == CYCLES_MAX) ? val : val + 16'd1;
   endfunction

endpackage

// File: rtl/counter_load_ctrl.sv
// Loads an external counter with a start value, steps it up to an end value
// while checking every value it reports, and returns a status/cycle result.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a request; req_ready high
// ST_LOAD  | ld_enb/data_in driven for one cycle; expected and cycles reset
// ST_COUNT | compare count_out with expected; step while below end/timeout
// ST_RESP  | done_valid held with status and cycles until done_ready
module counter_load_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_start,
   input  logic [WIDTH-1:0] req_end,
   output logic             ld_enb,
   output logic [WIDTH-1:0] data_in,
   output logic             count_enb,
   input  logic [WIDTH-1:0] count_out,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [1:0]       done_status,
   output logic [15:0]      done_cycles
);

   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   state_t             r_state;
   logic [WIDTH-1:0]   r_start;
   logic [WIDTH-1:0]   r_end;
   logic [WIDTH-1:0]   r_expected;
   logic [15:0]        r_cycles;
   logic               r_req_ready;
   logic               r_ld_enb;
   logic [WIDTH-1:0]   r_data_in;
   logic               r_done_valid;
   status_t            r_done_status;
   logic [15:0]        r_done_cycles;

   state_t             w_state_nxt;
   status_t            w_status_nxt;
   logic               w_match;
   logic               w_at_end;
   logic               w_below_tmo;

   assign w_match     = (count_out == r_expected);
   assign w_at_end    = (count_out == r_end);
   assign w_below_tmo = (r_cycles < TIMEOUT_C);

   // Step the counter only while it tracks expected and has room to go, so it stops exactly on end.
   assign count_enb = (r_state == ST_COUNT) && w_match && !w_at_end && w_below_tmo;

   // Next-state decode; in COUNT a mismatch outranks reaching end, which outranks timeout.
   always_comb begin
      w_state_nxt  = r_state;
      w_status_nxt = STAT_OK;
      case (r_state)
         ST_IDLE: begin
            if (req_valid && r_req_ready) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            w_state_nxt = ST_COUNT;
         end
         ST_COUNT: begin
            if (!w_match) begin
               w_state_nxt  = ST_RESP;
               w_status_nxt = STAT_MISMATCH;
            end else if (w_at_end) begin
               w_state_nxt  = ST_RESP;
               w_status_nxt = STAT_OK;
            end else if (r_cycles == TIMEOUT_C) begin
               w_state_nxt  = ST_RESP;
               w_status_nxt = STAT_TIMEOUT;
            end
         end
         ST_RESP: begin
            if (done_ready) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register plus every registered output; outputs change on the edge that enters a state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_start       <= '0;
         r_end         <= '0;
         r_expected    <= '0;
         r_cycles      <= '0;
         r_req_ready   <= 1'b1;
         r_ld_enb      <= 1'b0;
         r_data_in     <= '0;
         r_done_valid  <= 1'b0;
         r_done_status <= STAT_OK;
         r_done_cycles <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_state_nxt == ST_LOAD) begin
                  r_start     <= req_start;
                  r_end       <= req_end;
                  r_ld_enb    <= 1'b1;
                  r_data_in   <= req_start;
                  r_req_ready <= 1'b0;
               end
            end
            ST_LOAD: begin
               r_ld_enb   <= 1'b0;
               r_data_in  <= '0;
               r_expected <= r_start;
               r_cycles   <= '0;
            end
            ST_COUNT: begin
               if (count_enb) begin
                  r_expected <= r_expected + WIDTH'(1);
                  r_cycles   <= sat_inc(r_cycles);
               end
               if (w_state_nxt == ST_RESP) begin
                  r_done_valid  <= 1'b1;
                  r_done_status <= w_status_nxt;
                  r_done_cycles <= r_cycles;
               end
            end
            ST_RESP: begin
               if (w_state_nxt == ST_IDLE) begin
                  r_done_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
               end
            end
            default: begin
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign ld_enb      = r_ld_enb;
   assign data_in     = r_data_in;
   assign done_valid  = r_done_valid;
   assign done_status = r_done_status;
   assign done_cycles = r_done_cycles;

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Bench for counter_load_ctrl: two instances (default TIMEOUT and TIMEOUT=4),
// each driving a behavioural counter that can be told to skip a value.
module tb_counter_load_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_valid   [2];
   logic        req_ready   [2];
   logic [7:0]  req_start   [2];
   logic [7:0]  req_end     [2];
   logic        ld_enb      [2];
   logic [7:0]  data_in     [2];
   logic        count_enb   [2];
   logic [7:0]  count_out   [2];
   logic        done_valid  [2];
   logic        done_ready  [2];
   logic [1:0]  done_status [2];
   logic [15:0] done_cycles [2];

   int          skip_at [2];
   int          pulses  [2];
   logic [7:0]  cnt     [2];

   int          n_checks = 0;
   int          n_pass   = 0;
   bit          inv_on   = 1'b0;

   always #5 clk = ~clk;

   counter_load_ctrl #(.WIDTH(8)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_start(req_start[0]), .req_end(req_end[0]),
      .ld_enb(ld_enb[0]), .data_in(data_in[0]), .count_enb(count_enb[0]),
      .count_out(count_out[0]),
      .done_valid(done_valid[0]), .done_ready(done_ready[0]),
      .done_status(done_status[0]), .done_cycles(done_cycles[0])
   );

   counter_load_ctrl #(.WIDTH(8), .TIMEOUT(4)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_start(req_start[1]), .req_end(req_end[1]),
      .ld_enb(ld_enb[1]), .data_in(data_in[1]), .count_enb(count_enb[1]),
      .count_out(count_out[1]),
      .done_valid(done_valid[1]), .done_ready(done_ready[1]),
      .done_status(done_status[1]), .done_cycles(done_cycles[1])
   );

   assign count_out[0] = cnt[0];
   assign count_out[1] = cnt[1];

   // External counter: loads on ld_enb, steps on count_enb; the skip_at-th step adds 2.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (ld_enb[u]) begin
            cnt[u]    <= data_in[u];
            pulses[u] <= 0;
         end else if (count_enb[u]) begin
            pulses[u] <= pulses[u] + 1;
            cnt[u]    <= cnt[u] + ((pulses[u] + 1 == skip_at[u]) ? 8'd2 : 8'd1);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Cycle-by-cycle properties that must hold regardless of the request.
   always @(negedge clk) begin
      if (inv_on && !rst) begin
         for (int u = 0; u < 2; u++) begin
            if (ld_enb[u]) chk("inv_ld_and_count", {31'd0, count_enb[u]}, 32'd0);
            else           chk("inv_data_in_zero", {24'd0, data_in[u]}, 32'd0);
            if (done_valid[u]) chk("inv_ready_in_resp", {31'd0, req_ready[u]}, 32'd0);
         end
      end
   end

   // Result from the rules: n = min(distance, timeout) steps; a skipped step k<=n is a mismatch at k.
   function automatic void model(input int s, input int e, input int tmo, input int skip,
                                 output int st, output int cyc);
      int d;
      int n;
      d = (e - s) & 255;
      n = (d < tmo) ? d : tmo;
      if (skip >= 1 && skip <= n) begin
         st  = 2;
         cyc = skip;
      end else if (d <= tmo) begin
         st  = 0;
         cyc = d;
      end else begin
         st  = 1;
         cyc = tmo;
      end
   endfunction

   task automatic run_req(input int u, input logic [7:0] s, input logic [7:0] e,
                          input int skip, input int hold, input string tag);
      int exp_st;
      int exp_cyc;
      int k;
      logic [1:0]  st0;
      logic [15:0] cy0;
      model(int'(s), int'(e), (u == 0) ? 1023 : 4, skip, exp_st, exp_cyc);
      skip_at[u] = skip;
      k = 0;
      while (!req_ready[u] && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_ready"}, {31'd0, req_ready[u]}, 32'd1);
      req_valid[u] = 1'b1;
      req_start[u] = s;
      req_end[u]   = e;
      @(negedge clk);
      // keep req_valid up and scramble the operands: LOAD must ignore them
      req_start[u] = 8'($urandom);
      req_end[u]   = 8'($urandom);
      chk({tag, "_ld_enb"}, {31'd0, ld_enb[u]}, 32'd1);
      chk({tag, "_data_in"}, {24'd0, data_in[u]}, {24'd0, s});
      chk({tag, "_busy_ready"}, {31'd0, req_ready[u]}, 32'd0);
      @(negedge clk);
      req_valid[u] = 1'b0;
      chk({tag, "_ld_once"}, {31'd0, ld_enb[u]}, 32'd0);
      k = 0;
      while (!done_valid[u] && k < 1100) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done_seen"}, {31'd0, done_valid[u]}, 32'd1);
      chk({tag, "_status"}, {30'd0, done_status[u]}, exp_st);
      chk({tag, "_cycles"}, {16'd0, done_cycles[u]}, exp_cyc);
      chk({tag, "_enb_pulses"}, pulses[u], exp_cyc);
      chk({tag, "_enb_low_resp"}, {31'd0, count_enb[u]}, 32'd0);
      if (exp_st == 0) chk({tag, "_final_count"}, {24'd0, count_out[u]}, {24'd0, e});
      st0 = 2'(exp_st);
      cy0 = 16'(exp_cyc);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, {31'd0, done_valid[u]}, 32'd1);
         chk({tag, "_hold_status"}, {30'd0, done_status[u]}, {30'd0, st0});
         chk({tag, "_hold_cycles"}, {16'd0, done_cycles[u]}, {16'd0, cy0});
      end
      done_ready[u] = 1'b1;
      @(negedge clk);
      done_ready[u] = 1'b0;
      chk({tag, "_done_drop"}, {31'd0, done_valid[u]}, 32'd0);
      chk({tag, "_idle_ready"}, {31'd0, req_ready[u]}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s;
      int seen_done;
      for (int u = 0; u < 2; u++) begin
         req_valid[u]  = 1'b0;
         req_start[u]  = 8'd0;
         req_end[u]    = 8'd0;
         done_ready[u] = 1'b0;
         skip_at[u]    = 0;
         pulses[u]     = 0;
         cnt[u]        = 8'd0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
      chk("rst_ld_enb", {31'd0, ld_enb[0]}, 32'd0);
      chk("rst_count_enb", {31'd0, count_enb[0]}, 32'd0);
      chk("rst_data_in", {24'd0, data_in[0]}, 32'd0);
      chk("rst_done_valid", {31'd0, done_valid[0]}, 32'd0);
      chk("rst_done_status", {30'd0, done_status[0]}, 32'd0);
      chk("rst_done_cycles", {16'd0, done_cycles[0]}, 32'd0);
      chk("rst_req_ready_t4", {31'd0, req_ready[1]}, 32'd1);
      rst = 1'b0;
      inv_on = 1'b1;
      @(negedge clk);

      run_req(0, 8'd3,   8'd6,   0, 0, "basic_3_6");
      run_req(0, 8'hFE,  8'h01,  0, 1, "wrap_fe_01");
      run_req(0, 8'd5,   8'd5,   0, 0, "equal_5_5");
      run_req(0, 8'd3,   8'd9,   2, 0, "skip_4_6");
      run_req(1, 8'd0,   8'd10,  0, 3, "timeout_0_10");
      run_req(1, 8'd7,   8'd11,  0, 0, "exact_tmo_7_11");

      // Abort from COUNT with a synchronous reset; no response may follow.
      skip_at[0] = 0;
      req_valid[0] = 1'b1;
      req_start[0] = 8'd0;
      req_end[0]   = 8'd20;
      @(negedge clk);
      req_valid[0] = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_in_count", {31'd0, count_enb[0]}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", {31'd0, req_ready[0]}, 32'd1);
      chk("abort_count_enb", {31'd0, count_enb[0]}, 32'd0);
      chk("abort_done_valid", {31'd0, done_valid[0]}, 32'd0);
      chk("abort_done_cycles", {16'd0, done_cycles[0]}, 32'd0);
      seen_done = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_valid[0]) seen_done = 1;
      end
      chk("abort_no_response", seen_done, 32'd0);
      run_req(0, 8'd0, 8'd20, 0, 0, "after_abort");

      for (int i = 0; i < 20; i++) begin
         s = int'($urandom_range(0, 255));
         run_req(0, 8'(s), 8'(s + int'($urandom_range(0, 40))),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0,
                 int'($urandom_range(0, 3)), "rand_u0");
      end
      for (int i = 0; i < 20; i++) begin
         s = int'($urandom_range(0, 255));
         run_req(1, 8'(s), 8'(s + int'($urandom_range(0, 8))),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0,
                 int'($urandom_range(0, 3)), "rand_u1");
      end

      inv_on = 1'b0;
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/counter_load_ctrl.md
COUNTER_LOAD_CTRL -- requirements
Module: counter_load_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the counter data width.
REQ-002 SHALL have parameter TIMEOUT, default 1023, giving the maximum number of count cycles per request before abort.
REQ-003 SHALL use one clock and a synchronous active-high reset; rst is sampled only on the rising edge of clk.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  a load/count request is offered.
REQ-007 req_ready  output  1  the block accepts a request.
REQ-008 req_start  input  WIDTH  value to load into the counter.
REQ-009 req_end  input  WIDTH  terminal value at which counting stops.
REQ-010 ld_enb  output  1  counter load strobe.
REQ-011 data_in  output  WIDTH  counter load value.
REQ-012 count_enb  output  1  counter increment enable.
REQ-013 count_out  input  WIDTH  counter value; the counter updates one cycle after ld_enb or count_enb.
REQ-014 done_valid  output  1  a result is available.
REQ-015 done_ready  input  1  the consumer accepts the result.
REQ-016 done_status  output  2  result code: 0 OK, 1 TIMEOUT, 2 MISMATCH.
REQ-017 done_cycles  output  16  number of cycles in which count_enb was high for this request.

Function
REQ-018 SHALL implement the states IDLE, LOAD, COUNT and RESP.
REQ-019 IDLE: req_ready=1; on req_valid&&req_ready, capture req_start and req_end and go to LOAD.
REQ-020 LOAD: ld_enb=1 and data_in=captured start for exactly one cycle, expected=start, cycle count cleared, then go to COUNT.
REQ-021 COUNT compare: count_out is compared with expected every cycle.
REQ-022 COUNT mismatch: if count_out!=expected, go to RESP with status MISMATCH; this check has highest priority.
REQ-023 COUNT terminal: else if count_out==end, go to RESP with status OK.
REQ-024 COUNT timeout: else if cycle count==TIMEOUT, go to RESP with status TIMEOUT.
REQ-025 count_enb SHALL equal (state==COUNT) && (count_out==expected) && (count_out!=end) && (cycles<TIMEOUT), so the counter never overshoots end.
REQ-026 Each cycle count_enb=1: expected increments modulo 2^WIDTH and the cycle count increments, saturating at 16'hFFFF.
REQ-027 Wrap-around SHALL be legal: with start>end, counting passes through all-ones to zero.
REQ-028 start==end SHALL complete with OK and done_cycles=0, with no count_enb pulse.
REQ-029 RESP: done_valid=1 with done_status and done_cycles held stable until done_ready; then return to IDLE.
REQ-030 req_ready SHALL be 0 in every state except IDLE; req_* SHALL be ignored outside IDLE.
REQ-031 ld_enb and count_enb SHALL never be high in the same cycle.
REQ-032 data_in SHALL be 0 when ld_enb=0.

Reset
REQ-033 On rst: state=IDLE, req_ready=1, ld_enb=0, count_enb=0, data_in=0, done_valid=0, done_status=0, done_cycles=0, expected=0, and the captured start and end are 0.
REQ-034 rst asserted mid-operation (LOAD, COUNT or RESP) SHALL abort without producing a response; outputs take their reset values from the next cycle.

Structure
REQ-035 The state enum, the status enum and the status encodings SHALL live in a shared package, counter_ctrl_pkg.
REQ-036 SHALL be a single module with no sub-module; the next-state decode and count_enb are combinational, and all other outputs are registered.

Verification
REQ-037 start=3, end=6, done_ready=1, ideal counter -> ld_enb one cycle with data_in=3; count_enb high 3 cycles; done_status=0, done_cycles=3.
REQ-038 start=8'hFE, end=8'h01 -> count_out sequence FE, FF, 00, 01; done_status=0, done_cycles=3.
REQ-039 start=5, end=5 -> no count_enb; done_status=0, done_cycles=0.
REQ-040 Counter model skips a value (4 -> 6) during start=3, end=9 -> done_status=2 the cycle 6 is seen; count_enb low that cycle.
REQ-041 TIMEOUT=4, start=0, end=10 -> done_status=1, done_cycles=4; done_valid held while done_ready=0 for 3 cycles.
REQ-042 rst in COUNT at start=0, end=20 -> no done_valid; next cycle req_ready=1 and count_enb=0; a new request then completes normally.
